// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
//
// Writer side of the instruction memory. A program image arrives over an 8N1
// UART line as a frame:
//     0xA5, LEN (words), 4*LEN payload bytes, CSUM (XOR of payload bytes)
// Payload bytes are packed little-endian into 32-bit words and each finished
// word is written through a single-cycle write port. The CPU is held in reset
// (cpu_hold=1) until a complete, checksum-valid image has been loaded.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   uart_rx      serial input, idles high, asynchronous to clk
//   imem_we      one-cycle write strobe per assembled word
//   imem_addr    byte address of the word being written (multiple of 4)
//   imem_wdata   word being written, first received byte in bits [7:0]
//   cpu_hold     1 = keep the CPU in reset
//   load_done    1 = image loaded and verified
//   load_err     1 = last frame rejected
//   words_loaded number of words written in the current frame
// -----------------------------------------------------------------------------
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int MAX_WORDS    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-2:0] words_loaded
);

    localparam int                WL_W      = ADDR_W - 1;
    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]        SYNC_BYTE = 8'hA5;
    localparam logic [7:0]        MAX_LEN   = 8'(MAX_WORDS);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    // ---------------- UART receiver ----------------
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_valid, rx_frame_err;
    logic [7:0]       rx_byte;

    // ---------------- frame FSM ----------------
    state_t            state_q, state_d;
    logic [WL_W-1:0]   len_q, len_d;
    logic [WL_W-1:0]   words_q, words_d;
    logic [WL_W-1:0]   words_inc;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Two-flop synchronizer plus one extra stage so a true falling edge
    // (high then low) can be told apart from a line that is simply still low,
    // e.g. right after a stop bit that was sent as 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Receiver: start bit is re-checked at mid-bit so short glitches are
    // dropped; data bits enter at the MSB and shift right (LSB arrives first).
    // rx_valid / rx_frame_err are single-cycle strobes on the stop sample.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d     = '0;
                    rx_state_d   = RX_IDLE;
                    rx_valid     = rx_sync_q;
                    rx_frame_err = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = rx_shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign words_inc = words_q + WL_W'(1);

    // Frame parser. The write strobe, address, data and the word counter are
    // all registered together so the write cycle shows a consistent set.
    // Only lanes 0..2 are buffered; lane 3 goes straight from rx_byte.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        done_d  = (state_q == S_DONE);
        hold_d  = (state_q != S_DONE);
        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_byte == 8'd0 || rx_byte > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = WL_W'(rx_byte);
                        words_d = '0;
                        idx_d   = '0;
                        csum_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    csum_d = csum_q ^ rx_byte;
                    idx_d  = idx_q + 2'd1;
                    case (idx_q)
                        2'd0: asm_d[7:0]   = rx_byte;
                        2'd1: asm_d[15:8]  = rx_byte;
                        2'd2: asm_d[23:16] = rx_byte;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {rx_byte, asm_q};
                            addr_d  = ADDR_W'({words_q, 2'b00});
                            words_d = words_inc;
                            if (words_inc == len_q) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    state_d = (rx_byte == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                err_d = 1'b1;
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A broken stop bit aborts any frame in progress; before a frame
        // starts it is just line noise, and once loaded the UART is ignored.
        if (rx_frame_err && state_q != S_IDLE && state_q != S_DONE) begin
            state_d = S_ERR;
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_uart_loader
//
// Directed bench for imem_uart_loader with CLKS_PER_BIT=4. Frames are sent
// bit-serially; a monitor logs every write strobe and flags strobes wider
// than one cycle. Each scenario task compares outputs against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_imem_uart_loader;

    localparam int CPB = 4;

    logic        clk;
    logic        rst;
    logic        uart_rx;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [6:0]  words_loaded;

    int n_pass  = 0;
    int n_total = 0;

    int          wr_count = 0;
    int          wide_cnt = 0;
    logic        we_prev  = 1'b0;
    logic [7:0]  wr_addr [64];
    logic [31:0] wr_data [64];

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(8),
        .MAX_WORDS(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_err(load_err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (we_prev) wide_cnt = wide_cnt + 1;
            if (wr_count < 64) begin
                wr_addr[wr_count] = imem_addr;
                wr_data[wr_count] = imem_wdata;
            end
            wr_count = wr_count + 1;
        end
        we_prev = (imem_we === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        settle(2);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        uart_rx = 1'b1;
        settle(3);
        n_total++; if (imem_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", imem_we); else n_pass++;
        n_total++; if (imem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", imem_addr); else n_pass++;
        n_total++; if (imem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 0", imem_wdata); else n_pass++;
        n_total++; if (cpu_hold !== 1'b1) $display("FAIL reset_hold: got %0b want 1", cpu_hold); else n_pass++;
        n_total++; if (load_done !== 1'b0) $display("FAIL reset_done: got %0b want 0", load_done); else n_pass++;
        n_total++; if (load_err !== 1'b0) $display("FAIL reset_err: got %0b want 0", load_err); else n_pass++;
        n_total++; if (words_loaded !== 7'd0) $display("FAIL reset_words: got %0d want 0", words_loaded); else n_pass++;
        rst = 1'b1;
        settle(2);
    endtask

    task automatic test_single_word();
        logic [7:0] f [7] = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        int base;
        do_reset();
        base = wr_count;
        for (int i = 0; i < 7; i++) send_byte(f[i], 1'b1);
        settle(4);
        n_total++; if (wr_count - base !== 1) $display("FAIL single_wr_count: got %0d want 1", wr_count - base); else n_pass++;
        n_total++; if (wr_addr[base] !== 8'h00) $display("FAIL single_addr: got %h want 00", wr_addr[base]); else n_pass++;
        n_total++; if (wr_data[base] !== 32'h00000013) $display("FAIL single_data: got %h want 00000013", wr_data[base]); else n_pass++;
        n_total++; if (load_done !== 1'b1) $display("FAIL single_done: got %0b want 1", load_done); else n_pass++;
        n_total++; if (cpu_hold !== 1'b0) $display("FAIL single_hold: got %0b want 0", cpu_hold); else n_pass++;
        n_total++; if (words_loaded !== 7'd1) $display("FAIL single_words: got %0d want 1", words_loaded); else n_pass++;
        // DONE ignores the UART: a would-be bad frame changes nothing.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        settle(4);
        n_total++; if (load_done !== 1'b1 || load_err !== 1'b0) $display("FAIL done_sticky: got done=%0b err=%0b want 1/0", load_done, load_err); else n_pass++;
    endtask

    task automatic test_three_word();
        logic [7:0] f [15] = '{8'hA5, 8'h03,
                               8'h01, 8'h02, 8'h03, 8'h04,
                               8'hAA, 8'hBB, 8'hCC, 8'hDD,
                               8'h10, 8'h20, 8'h30, 8'h40,
                               8'h44};
        logic [31:0] exp_d [3] = '{32'h04030201, 32'hDDCCBBAA, 32'h40302010};
        logic [7:0]  exp_a [3] = '{8'h00, 8'h04, 8'h08};
        int base, wbase;
        do_reset();
        base  = wr_count;
        wbase = wide_cnt;
        for (int i = 0; i < 15; i++) send_byte(f[i], 1'b1);
        settle(4);
        n_total++; if (wr_count - base !== 3) $display("FAIL three_wr_count: got %0d want 3", wr_count - base); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (wr_addr[base+k] !== exp_a[k]) $display("FAIL three_addr%0d: got %h want %h", k, wr_addr[base+k], exp_a[k]); else n_pass++;
            n_total++; if (wr_data[base+k] !== exp_d[k]) $display("FAIL three_data%0d: got %h want %h", k, wr_data[base+k], exp_d[k]); else n_pass++;
        end
        n_total++; if (wide_cnt - wbase !== 0) $display("FAIL three_pulse_width: got %0d wide strobes want 0", wide_cnt - wbase); else n_pass++;
        n_total++; if (load_done !== 1'b1) $display("FAIL three_done: got %0b want 1", load_done); else n_pass++;
        n_total++; if (words_loaded !== 7'd3) $display("FAIL three_words: got %0d want 3", words_loaded); else n_pass++;
    endtask

    task automatic test_bad_csum();
        logic [7:0] f [11] = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        logic [7:0] g [7]  = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        int base;
        do_reset();
        base = wr_count;
        for (int i = 0; i < 11; i++) send_byte(f[i], 1'b1);
        settle(4);
        n_total++; if (load_err !== 1'b1) $display("FAIL csum_err: got %0b want 1", load_err); else n_pass++;
        n_total++; if (cpu_hold !== 1'b1) $display("FAIL csum_hold: got %0b want 1", cpu_hold); else n_pass++;
        n_total++; if (load_done !== 1'b0) $display("FAIL csum_done: got %0b want 0", load_done); else n_pass++;
        n_total++; if (wr_count - base !== 2) $display("FAIL csum_wr_count: got %0d want 2", wr_count - base); else n_pass++;
        for (int i = 0; i < 7; i++) send_byte(g[i], 1'b1);
        settle(4);
        n_total++; if (load_err !== 1'b0) $display("FAIL recover_err: got %0b want 0", load_err); else n_pass++;
        n_total++; if (load_done !== 1'b1) $display("FAIL recover_done: got %0b want 1", load_done); else n_pass++;
        n_total++; if (wr_count - base !== 3) $display("FAIL recover_wr_count: got %0d want 3", wr_count - base); else n_pass++;
        n_total++; if (wr_addr[base+2] !== 8'h00 || wr_data[base+2] !== 32'h12345678) $display("FAIL recover_write: got %h@%h want 12345678@00", wr_data[base+2], wr_addr[base+2]); else n_pass++;
    endtask

    task automatic test_len_bounds();
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        settle(4);
        n_total++; if (load_err !== 1'b0) $display("FAIL garbage_err: got %0b want 0", load_err); else n_pass++;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        settle(4);
        n_total++; if (load_err !== 1'b1) $display("FAIL len0_err: got %0b want 1", load_err); else n_pass++;
        send_byte(8'hA5, 1'b1);
        settle(4);
        n_total++; if (load_err !== 1'b0) $display("FAIL sync_clears_err: got %0b want 0", load_err); else n_pass++;
        send_byte(8'h41, 1'b1);
        settle(4);
        n_total++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) $display("FAIL len65_err: got err=%0b hold=%0b want 1/1", load_err, cpu_hold); else n_pass++;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h40, 1'b1);
        settle(4);
        n_total++; if (load_err !== 1'b0) $display("FAIL len64_accept: got err=%0b want 0", load_err); else n_pass++;
        n_total++; if (wr_count - base !== 0) $display("FAIL len_no_write: got %0d writes want 0", wr_count - base); else n_pass++;
    endtask

    task automatic test_framing();
        logic [7:0] g [5] = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int base;
        do_reset();
        base = wr_count;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        settle(4);
        n_total++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) $display("FAIL frame_data_err: got err=%0b hold=%0b want 1/1", load_err, cpu_hold); else n_pass++;
        n_total++; if (wr_count - base !== 0) $display("FAIL frame_no_write: got %0d writes want 0", wr_count - base); else n_pass++;
        // Framing error while idle is ignored.
        do_reset();
        send_byte(8'hA5, 1'b0);
        settle(4);
        n_total++; if (load_err !== 1'b0) $display("FAIL frame_idle_ignored: got err=%0b want 0", load_err); else n_pass++;
        // Glitch after the sync byte; a phantom 0xFF LEN would abort the frame.
        do_reset();
        base = wr_count;
        send_byte(8'hA5, 1'b1);
        settle(3);
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        settle(10);
        for (int i = 0; i < 5; i++) send_byte(g[i], 1'b1);
        send_byte(8'h22, 1'b1);
        settle(4);
        n_total++; if (load_done !== 1'b1 || load_err !== 1'b0) $display("FAIL glitch_ignored: got done=%0b err=%0b want 1/0", load_done, load_err); else n_pass++;
        n_total++; if (wr_count - base !== 1 || wr_data[base] !== 32'hDEADBEEF) $display("FAIL glitch_write: got %0d writes data %h want 1 DEADBEEF", wr_count - base, wr_data[base]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] f [8] = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] g [7] = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        int base;
        do_reset();
        base = wr_count;
        for (int i = 0; i < 8; i++) send_byte(f[i], 1'b1);
        settle(3);
        n_total++; if (words_loaded !== 7'd1 || imem_wdata !== 32'h44332211) $display("FAIL mid_pre: got words=%0d data=%h want 1 44332211", words_loaded, imem_wdata); else n_pass++;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_total++; if (imem_wdata !== 32'h0 || words_loaded !== 7'd0) $display("FAIL mid_async: got data=%h words=%0d want 0/0", imem_wdata, words_loaded); else n_pass++;
        n_total++; if (cpu_hold !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 8'h00) $display("FAIL mid_async_ctl: got hold=%0b we=%0b addr=%h want 1/0/00", cpu_hold, imem_we, imem_addr); else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        settle(8);
        n_total++; if (wr_count - base !== 1) $display("FAIL mid_no_partial: got %0d writes want 1", wr_count - base); else n_pass++;
        for (int i = 0; i < 7; i++) send_byte(g[i], 1'b1);
        settle(4);
        n_total++; if (wr_count - base !== 2 || wr_addr[base+1] !== 8'h00 || wr_data[base+1] !== 32'hDEADBEEF) $display("FAIL mid_reload: got %0d writes %h@%h want 2 DEADBEEF@00", wr_count - base, wr_data[base+1], wr_addr[base+1]); else n_pass++;
        n_total++; if (load_done !== 1'b1 || cpu_hold !== 1'b0) $display("FAIL mid_reload_done: got done=%0b hold=%0b want 1/0", load_done, cpu_hold); else n_pass++;
    endtask

    initial begin
        rst = 1'b0;
        uart_rx = 1'b1;
        test_reset();
        $display("[TB] reset checked");
        test_single_word();
        $display("[TB] single word frame checked");
        test_three_word();
        $display("[TB] three word frame checked");
        test_bad_csum();
        $display("[TB] checksum rejection checked");
        test_len_bounds();
        $display("[TB] length bounds checked");
        test_framing();
        $display("[TB] framing and glitch checked");
        test_reset_mid();
        $display("[TB] mid-frame reset checked");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
